// File: rtl/fb_access_ctrl.sv
// Frame-buffer port arbiter: display reads win during active video, and blank
// cycles go to a full-buffer clear engine or to single drawing-engine writes.
module fb_access_ctrl #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int FB_DEPTH  = 19200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [16:0] disp_addr,
    input  logic        wr_req,
    input  logic [16:0] wr_addr,
    input  logic [11:0] wr_data,
    output logic        wr_ack,
    input  logic        clr_start,
    input  logic [11:0] clr_color,
    output logic        clr_busy,
    output logic        clr_done,
    output logic [16:0] ram_addr,
    output logic [11:0] ram_din,
    output logic        ram_we,
    output logic        disp_valid
);

    localparam logic [14:0] LAST_PTR = 15'(FB_DEPTH - 1);
    localparam logic [16:0] DEPTH_17 = 17'(FB_DEPTH);

    generate
        if (FB_DEPTH != FB_WIDTH * FB_HEIGHT) begin : g_bad_depth
            $error("fb_access_ctrl: FB_DEPTH must equal FB_WIDTH*FB_HEIGHT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [14:0] clr_ptr_r, clr_ptr_s;
    logic [11:0] clr_color_r, clr_color_s;
    logic        active_s;
    logic [16:0] ram_addr_s;
    logic [11:0] ram_din_s;
    logic        ram_we_s;
    logic        wr_ack_s;
    logic        clr_busy_s;
    logic        clr_done_s;

    assign active_s = (h_cnt < 10'd640) && (v_cnt < 10'd480);

    // State, clear pointer and latched fill colour
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            clr_ptr_r   <= 15'd0;
            clr_color_r <= 12'd0;
        end else begin
            state_r     <= state_s;
            clr_ptr_r   <= clr_ptr_s;
            clr_color_r <= clr_color_s;
        end
    end

    // Next-state and next-output decode for the shared RAM port
    always_comb begin
        state_s     = state_r;
        clr_ptr_s   = clr_ptr_r;
        clr_color_s = clr_color_r;
        ram_addr_s  = ram_addr;
        ram_din_s   = ram_din;
        ram_we_s    = 1'b0;
        wr_ack_s    = 1'b0;
        if (active_s) begin
            ram_addr_s = disp_addr;
        end else begin
            ram_addr_s = ram_addr;
        end
        case (state_r)
            IDLE: begin
                if (clr_start) begin
                    clr_color_s = clr_color;
                    clr_ptr_s   = 15'd0;
                    state_s     = CLEAR;
                // The ack cycle itself is skipped: the requester only sees ack then.
                end else if (!active_s && wr_req && !wr_ack) begin
                    ram_addr_s = wr_addr;
                    ram_din_s  = wr_data;
                    ram_we_s   = (wr_addr < DEPTH_17);
                    wr_ack_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: begin
                if (!active_s) begin
                    ram_addr_s = {2'b00, clr_ptr_r};
                    ram_din_s  = clr_color_r;
                    ram_we_s   = 1'b1;
                    clr_ptr_s  = clr_ptr_r + 15'd1;
                    if (clr_ptr_r == LAST_PTR) begin
                        state_s = DONE;
                    end else begin
                        state_s = CLEAR;
                    end
                end else begin
                    clr_ptr_s = clr_ptr_r;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        clr_busy_s = (state_s != IDLE);
        clr_done_s = (state_s == DONE);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr   <= 17'd0;
            ram_din    <= 12'd0;
            ram_we     <= 1'b0;
            wr_ack     <= 1'b0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            ram_addr   <= ram_addr_s;
            ram_din    <= ram_din_s;
            ram_we     <= ram_we_s;
            wr_ack     <= wr_ack_s;
            clr_busy   <= clr_busy_s;
            clr_done   <= clr_done_s;
            disp_valid <= active_s;
        end
    end

endmodule

// File: tb/tb_fb_access_ctrl.sv
// Directed bench for fb_access_ctrl: display reads, writes, clear, conflicts, reset.
module tb_fb_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [16:0] disp_addr;
    logic        wr_req;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        clr_start;
    logic [11:0] clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [16:0] ram_addr;
    logic [11:0] ram_din;
    logic        ram_we;
    logic        disp_valid;

    int checks = 0;
    int errors = 0;

    fb_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .disp_addr  (disp_addr),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_din"},  32'(ram_din),  32'd0);
        chk({tag, "_ctl"},  {25'd0, ram_we, wr_ack, clr_busy, clr_done, disp_valid, 2'b00}, 32'd0);
    endtask

    initial begin
        int bad;
        int waited;
        bit acked;

        rst = 1'b0; h_cnt = 10'd700; v_cnt = 10'd0; disp_addr = 17'd0;
        wr_req = 1'b0; wr_addr = 17'd0; wr_data = 12'd0;
        clr_start = 1'b0; clr_color = 12'd0;
        tick();
        chk_all_zero("reset");
        rst = 1'b1;

        // Active read
        h_cnt = 10'd100; v_cnt = 10'd50; disp_addr = 17'd2025;
        tick();
        chk("rd_addr", 32'(ram_addr), 32'd2025);
        chk("rd_we", 32'(ram_we), 32'd0);
        chk("rd_valid", 32'(disp_valid), 32'd1);

        // Blank idle: address holds
        h_cnt = 10'd700;
        tick();
        chk("idle_hold", {ram_addr, 13'd0, ram_we, disp_valid}, {17'd2025, 15'd0});

        // Blank write
        wr_req = 1'b1; wr_addr = 17'd300; wr_data = 12'hF00;
        tick();
        chk("wr_port", {3'd0, ram_addr, ram_din}, {3'd0, 17'd300, 12'hF00});
        chk("wr_ctl", {30'd0, ram_we, wr_ack}, 32'd3);
        wr_req = 1'b0;
        tick();
        chk("wr_ack_pulse", {30'd0, ram_we, wr_ack}, 32'd0);

        // Held request: ack cycle is skipped, then it is a new request
        wr_req = 1'b1; wr_addr = 17'd301; wr_data = 12'h0AB;
        tick();
        chk("held_ack1", {13'd0, ram_addr, ram_we, wr_ack}, {13'd0, 17'd301, 2'b11});
        tick();
        chk("held_gap", {30'd0, ram_we, wr_ack}, 32'd0);
        tick();
        chk("held_ack2", {30'd0, ram_we, wr_ack}, 32'd3);
        wr_req = 1'b0;
        tick();

        // Out-of-range write: acknowledged, dropped
        wr_req = 1'b1; wr_addr = 17'd19200; wr_data = 12'h555;
        tick();
        chk("oor", {13'd0, ram_addr, ram_we, wr_ack}, {13'd0, 17'd19200, 2'b01});
        wr_req = 1'b0; wr_addr = 17'd19199;
        tick();
        wr_req = 1'b1;
        tick();
        chk("last_in_range", {30'd0, ram_we, wr_ack}, 32'd3);
        wr_req = 1'b0;
        tick();

        // Deferred write during active video
        h_cnt = 10'd100; disp_addr = 17'd7;
        wr_req = 1'b1; wr_addr = 17'd500; wr_data = 12'h123;
        tick();
        chk("defer1", {13'd0, ram_addr, ram_we, wr_ack}, {13'd0, 17'd7, 2'b00});
        tick();
        chk("defer2", {30'd0, ram_we, wr_ack}, 32'd0);
        h_cnt = 10'd700;
        tick();
        chk("defer_ack", {1'b0, ram_addr, ram_din, ram_we, wr_ack}, {1'b0, 17'd500, 12'h123, 2'b11});
        chk("defer_valid", 32'(disp_valid), 32'd0);
        wr_req = 1'b0;
        tick();

        // Full clear with a short active pause
        clr_start = 1'b1; clr_color = 12'h0F0;
        tick();
        chk("clr_start", {29'd0, clr_busy, ram_we, wr_ack}, 32'd4);
        clr_start = 1'b0; clr_color = 12'h000;
        bad = -1;
        for (int i = 0; i < 19200; i++) begin
            if (i == 100) begin
                for (int k = 0; k < 3; k++) begin
                    h_cnt = 10'd100; disp_addr = 17'(9000 + k);
                    tick();
                    if (bad < 0 && (ram_we !== 1'b0 || ram_addr !== 17'(9000 + k) ||
                                    disp_valid !== 1'b1 || clr_busy !== 1'b1))
                        bad = 100000 + k;
                end
                h_cnt = 10'd700;
            end
            tick();
            if (bad < 0 && (ram_we !== 1'b1 || ram_addr !== 17'(i) || ram_din !== 12'h0F0 ||
                            clr_busy !== 1'b1 || clr_done !== (i == 19199)))
                bad = i;
        end
        chk("clr_seq", 32'(bad), 32'hFFFF_FFFF);
        tick();
        chk("clr_end", {29'd0, clr_busy, clr_done, ram_we}, 32'd0);

        // Clear and write requested together
        clr_start = 1'b1; clr_color = 12'h00F;
        wr_req = 1'b1; wr_addr = 17'd42; wr_data = 12'hABC;
        tick();
        chk("conf_start", {30'd0, clr_busy, wr_ack}, 32'd2);
        clr_start = 1'b0;
        acked = 1'b0; waited = 0;
        while (clr_busy === 1'b1 && waited < 30000) begin
            tick();
            waited++;
            if (wr_ack === 1'b1) acked = 1'b1;
        end
        chk("conf_timeout", 32'(clr_busy), 32'd0);
        chk("conf_no_early_ack", 32'(acked), 32'd0);
        tick();
        chk("conf_ack", {13'd0, ram_addr, ram_we, wr_ack}, {13'd0, 17'd42, 2'b11});
        wr_req = 1'b0;
        tick();

        // Reset in the middle of a clear
        clr_start = 1'b1; clr_color = 12'hFFF;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 5000; i++) tick();
        chk("mid_clr_addr", 32'(ram_addr), 32'd4999);
        rst = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        tick();
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ram_we !== 1'b0 || clr_busy !== 1'b0) bad++;
        end
        chk("post_rst_idle", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
